// File: rtl/bias_accum_adder.sv
// -----------------------------------------------------------------------------
// bias_accum_adder
//
// Purpose:
//   Accumulates N_PASS partial-sum beats per lane from an adder tree, adds a
//   per-lane bias on the first beat of each group, saturates the final sum to
//   the signed 18-bit range and presents it on a valid/ready output register.
//   While a finished result waits for the consumer, the next group keeps
//   accumulating; only its final beat is stalled.
//
// Optional build macro:
//   BIAS_ACCUM_RELU_EN - when defined, negative saturated results are clamped
//                        to 0 (fused ReLU). Interface and timing are unchanged.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   bias_q    - packed per-lane signed biases, lane i at [18*i +: 18]
//   in_data   - packed signed partial sums, lane i at [18*i +: 18]
//   in_valid  - in_data is valid
//   in_ready  - block accepts in_data this cycle
//   out_data  - packed biased, saturated results
//   out_valid - out_data holds a result
//   out_ready - consumer takes the result this cycle
//   pass_cnt  - beats accepted so far in the current group
// -----------------------------------------------------------------------------
module bias_accum_adder #(
  parameter int N_adder_tree = 16,
  parameter int N_PASS       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_adder_tree*18-1:0]   bias_q,
  input  logic [N_adder_tree*18-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N_adder_tree*18-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_PASS):0]      pass_cnt
);

  localparam int PCW  = $clog2(N_PASS) + 1;
  // Wide enough for N_PASS beats plus the bias without wrapping.
  localparam int ACCW = 18 + PCW;
  localparam logic [PCW-1:0] LAST_BEAT = PCW'(N_PASS - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(131071);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-131072);

  logic [PCW-1:0]               r_pass_cnt;
  logic                         r_out_valid;
  logic [N_adder_tree*18-1:0]   r_out_data;
  logic [N_adder_tree*18-1:0]   w_result;

  logic w_first;
  logic w_last;
  logic w_in_ready;
  logic w_accept;
  logic w_final;

  assign w_first = (r_pass_cnt == '0);
  assign w_last  = (r_pass_cnt == LAST_BEAT);
  // Only the final beat needs a free output slot; a slot being drained this
  // cycle counts as free, which gives back-to-back results without a bubble.
  assign w_in_ready = rst | ~(w_last & r_out_valid & ~out_ready);
  assign w_accept   = in_valid & w_in_ready & ~rst;
  assign w_final    = w_accept & w_last;

  genvar gi;
  generate
    for (gi = 0; gi < N_adder_tree; gi++) begin : g_lane
      logic signed [ACCW-1:0] r_acc;
      logic signed [ACCW-1:0] w_in_ext;
      logic signed [ACCW-1:0] w_bias_ext;
      logic signed [ACCW-1:0] w_sum;
      logic signed [17:0]     w_sat;
      logic signed [17:0]     w_res;

      assign w_in_ext   = {{(ACCW-18){in_data[18*gi+17]}}, in_data[18*gi +: 18]};
      assign w_bias_ext = {{(ACCW-18){bias_q[18*gi+17]}},  bias_q[18*gi +: 18]};
      // Bias enters only on the first beat, so mid-group bias changes are ignored.
      assign w_sum = w_first ? (w_in_ext + w_bias_ext) : (r_acc + w_in_ext);

      always_comb begin
        w_sat = w_sum[17:0];
        if (w_sum > SAT_MAX) begin
          w_sat = 18'sd131071;
        end else if (w_sum < SAT_MIN) begin
          w_sat = -18'sd131072;
        end
      end

`ifdef BIAS_ACCUM_RELU_EN
      assign w_res = w_sat[17] ? 18'sd0 : w_sat;
`else
      assign w_res = w_sat;
`endif

      assign w_result[18*gi +: 18] = w_res;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_acc <= '0;
        end else if (w_accept) begin
          r_acc <= w_sum;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_accept) begin
        r_pass_cnt <= w_last ? '0 : (r_pass_cnt + PCW'(1));
      end
      if (w_final) begin
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign pass_cnt  = r_pass_cnt;

endmodule

// File: tb/tb_bias_accum_adder.sv
// -----------------------------------------------------------------------------
// tb_bias_accum_adder
//
// Directed testbench for bias_accum_adder with two lanes and four beats per
// group, followed by a throttled run checked against a small sum/saturate
// model. Inputs change 1 ns after the rising edge; outputs are checked 3 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_bias_accum_adder;

  localparam int NL = 2;
  localparam int NP = 4;
  localparam int W  = NL * 18;
  localparam int NG = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  bias_q;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    pass_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bias_accum_adder #(.N_adder_tree(NL), .N_PASS(NP)) dut (
    .clk      (clk),
    .rst      (rst),
    .bias_q   (bias_q),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pass_cnt (pass_cnt)
  );

  function automatic logic [W-1:0] pack2(int a, int b);
    logic [17:0] ta;
    logic [17:0] tb;
    ta = a[17:0];
    tb = b[17:0];
    return {tb, ta};
  endfunction

  function automatic logic signed [31:0] lane(logic [W-1:0] v, int i);
    logic signed [17:0] t;
    t = v[18*i +: 18];
    return 32'(t);
  endfunction

  function automatic logic signed [31:0] ref_sat(longint s);
    longint r;
    r = s;
    if (r > 131071)  r = 131071;
    if (r < -131072) r = -131072;
`ifdef BIAS_ACCUM_RELU_EN
    if (r < 0) r = 0;
`endif
    return 32'(r);
  endfunction

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(int a0, int a1);
    in_valid = 1'b1;
    in_data  = pack2(a0, a1);
    #2;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    #2;
  endtask

  // Throttled-run state
  logic signed [31:0] q0[$];
  logic signed [31:0] q1[$];
  longint acc0, acc1;
  int     mbeat, g_in, g_out, cycles;
  int     rb0, rb1, r0, r1;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    bias_q = '0; in_data = '0;

    // ---- reset state ----
    tick(); tick(); #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_pass_cnt",  32'(pass_cnt), 0);
    chk("rst_lane0",     lane(out_data, 0), 0);
    chk("rst_lane1",     lane(out_data, 1), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
    rst = 1'b0;
    tick(); #2;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // ---- A: basic accumulate + bias, positive saturation on lane1 ----
    bias_q = pack2(-392, 49820);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = pack2(100 * (k + 1), 30000);
      #2;
      chk("A_pass_cnt", 32'(pass_cnt), k);
      tick();
    end
    idle();
    chk("A_out_valid", 32'(out_valid), 1);
    chk("A_lane0", lane(out_data, 0), 608);
    chk("A_lane1_satpos", lane(out_data, 1), 131071);
    chk("A_pass_cnt_wrap", 32'(pass_cnt), 0);
    $display("group A: lane0=%0d lane1=%0d", lane(out_data, 0), lane(out_data, 1));
    tick(); #2;
    chk("A_valid_one_cycle", 32'(out_valid), 0);

    // ---- B: negative saturation, bias change mid-group ignored ----
    for (int k = 0; k < 4; k++) begin
      if (k == 1) bias_q = pack2(5000, 5000);
      beat(-40000, 0);
    end
    bias_q = pack2(-392, 49820);
    idle();
    chk("B_lane0_satneg", lane(out_data, 0), ref_sat(-160392));
    chk("B_lane1_bias_hold", lane(out_data, 1), 49820);
    $display("group B: lane0=%0d lane1=%0d", lane(out_data, 0), lane(out_data, 1));
    tick();

    // ---- C: backpressure, second group accumulates while result 1 is held ----
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) beat(k + 1, 10);
    idle();
    chk("C_r1_valid", 32'(out_valid), 1);
    chk("C_r1_lane0", lane(out_data, 0), -382);
    chk("C_r1_lane1", lane(out_data, 1), 49860);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = pack2(1000, -100);
      #2;
      chk("C_in_ready", 32'(in_ready), (k < 3) ? 1 : 0);
      if (k < 3) tick();
    end
    tick(); #2;
    chk("C_stall_in_ready", 32'(in_ready), 0);
    chk("C_stall_pass_cnt", 32'(pass_cnt), 3);
    chk("C_hold_valid", 32'(out_valid), 1);
    chk("C_hold_lane0", lane(out_data, 0), -382);
    out_ready = 1'b1;
    #2;
    chk("C_release_in_ready", 32'(in_ready), 1);
    tick();
    idle();
    chk("C_r2_valid", 32'(out_valid), 1);
    chk("C_r2_lane0", lane(out_data, 0), 3608);
    chk("C_r2_lane1", lane(out_data, 1), 49420);
    $display("group C: lane0=%0d lane1=%0d", lane(out_data, 0), lane(out_data, 1));
    tick(); #2;
    chk("C_r2_drained", 32'(out_valid), 0);

    // ---- D: reset drops held result and partial group ----
    out_ready = 1'b0;
    bias_q = pack2(0, 0);
    for (int k = 0; k < 4; k++) beat(7, 7);
    beat(999, 999);
    beat(999, 999);
    idle();
    chk("D_held_valid", 32'(out_valid), 1);
    chk("D_partial_cnt", 32'(pass_cnt), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    chk("D_rst_valid", 32'(out_valid), 0);
    chk("D_rst_lane0", lane(out_data, 0), 0);
    chk("D_rst_pass_cnt", 32'(pass_cnt), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) beat(10, -10);
    idle();
    chk("D_lane0", lane(out_data, 0), 40);
    chk("D_lane1", lane(out_data, 1), ref_sat(-40));
    $display("group D: lane0=%0d lane1=%0d", lane(out_data, 0), lane(out_data, 1));
    tick();

    // ---- E: negative result, ReLU build clamps to zero ----
    bias_q = pack2(-392, 100);
    for (int k = 0; k < 4; k++) beat(0, -50);
    idle();
`ifdef BIAS_ACCUM_RELU_EN
    chk("E_lane0_relu", lane(out_data, 0), 0);
    chk("E_lane1_relu", lane(out_data, 1), 0);
`else
    chk("E_lane0_neg", lane(out_data, 0), -392);
    chk("E_lane1_neg", lane(out_data, 1), -100);
`endif
    $display("group E: lane0=%0d lane1=%0d", lane(out_data, 0), lane(out_data, 1));
    tick();

    // ---- F: throttled groups against the reference model ----
    rb0 = $urandom_range(0, 262143) - 131072;
    rb1 = $urandom_range(0, 262143) - 131072;
    bias_q = pack2(rb0, rb1);
    mbeat = 0; g_in = 0; g_out = 0; cycles = 0; acc0 = 0; acc1 = 0;
    while ((g_out < NG) && (cycles < 20000)) begin
      in_valid  = (g_in < NG) ? ($urandom_range(0, 3) != 0) : 1'b0;
      r0 = $urandom_range(0, 262143) - 131072;
      r1 = $urandom_range(0, 262143) - 131072;
      in_data   = pack2(r0, r1);
      out_ready = ($urandom_range(0, 2) != 0);
      #2;
      if (out_valid && out_ready) begin
        if (q0.size() == 0) begin
          chk("F_unexpected_output", 32'(out_valid), 0);
        end else begin
          chk("F_lane0", lane(out_data, 0), q0.pop_front());
          chk("F_lane1", lane(out_data, 1), q1.pop_front());
          $display("F group %0d: lane0=%0d lane1=%0d", g_out, lane(out_data, 0), lane(out_data, 1));
        end
        g_out++;
      end
      if (in_valid && in_ready) begin
        if (mbeat == 0) begin
          acc0 = longint'(r0) + longint'(rb0);
          acc1 = longint'(r1) + longint'(rb1);
        end else begin
          acc0 = acc0 + longint'(r0);
          acc1 = acc1 + longint'(r1);
        end
        mbeat++;
        if (mbeat == NP) begin
          q0.push_back(ref_sat(acc0));
          q1.push_back(ref_sat(acc1));
          mbeat = 0;
          g_in++;
        end
      end
      tick();
      cycles++;
    end
    chk("F_groups_out", g_out, NG);
    chk("F_queue_empty", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
